// File: rtl/clks_alot_p.sv
// clks_alot_p: shared deserializer state encoding and default sizing
package clks_alot_p;
    typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, ALIGNED = 2'd2} deser_state_e;
    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_SYNC_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/deser_fifo.sv
// deser_fifo: synchronous first-word-fall-through word buffer with wrap-bit pointers
module deser_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             clk_en,
    input  logic             clear,
    input  logic             push,
    input  logic             ready,
    input  logic [WIDTH-1:0] wdata,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    logic empty, pop, wr_ok;
    assign empty = wr == rd;
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign pop   = clk_en && ready && !empty;
    assign wr_ok = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign valid = !empty;
    assign rdata = empty ? '0 : mem[rd[AW-1:0]];
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr <= '0;
            rd <= '0;
        end else if (clk_en) begin
            if (clear) begin
                wr <= '0;
                rd <= '0;
            end else begin
                if (wr_ok) wr <= wr + 1'b1;
                if (pop) rd <= rd + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (clk_en && !clear && wr_ok) mem[wr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/recovered_deserializer.sv
// recovered_deserializer: sync-pattern aligned serial-to-word converter feeding a FWFT buffer
module recovered_deserializer
    import clks_alot_p::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  clk_en,
    input  logic                  deser_en_i,
    input  logic                  clear_state_i,
    input  logic                  fully_locked_in_i,
    input  logic                  sample_event_i,
    input  logic                  data_pin_i,
    input  logic                  msb_first_i,
    input  logic [SYNC_WIDTH-1:0] sync_pattern_i,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic [WORD_WIDTH-1:0] word_data_o,
    output logic                  overflow_o,
    output logic [1:0]            state_o
);
    localparam int CW = $clog2(WORD_WIDTH);
    deser_state_e state, state_n;
    logic [SYNC_WIDTH-1:0] hist;
    logic [WORD_WIDTH-1:0] shreg, shift_n;
    logic [CW-1:0] cnt;
    logic msb, active, sample, last, push, stay_aligned, drop, full;
    assign active       = deser_en_i && fully_locked_in_i;
    assign sample       = clk_en && sample_event_i;
    assign stay_aligned = state == ALIGNED && state_n == ALIGNED;
    assign last         = cnt == CW'(WORD_WIDTH - 1);
    assign push         = sample && stay_aligned && last;
    assign shift_n      = msb ? {shreg[WORD_WIDTH-2:0], data_pin_i} : {data_pin_i, shreg[WORD_WIDTH-1:1]};
    assign state_o      = state;
    always_comb begin
        state_n = state;
        if (clear_state_i) state_n = IDLE;
        else if (state == IDLE) state_n = active ? HUNT : IDLE;
        else if (!active) state_n = IDLE;
        else if (state == HUNT && hist == sync_pattern_i) state_n = ALIGNED;
    end
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state <= IDLE;
        else if (clk_en) state <= state_n;
    end
    // Any exit from HUNT/ALIGNED discards history and partial word so resync starts clean
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            hist       <= '0;
            shreg      <= '0;
            cnt        <= '0;
            msb        <= 1'b0;
            overflow_o <= 1'b0;
        end else if (clk_en) begin
            hist <= (state == HUNT && state_n == HUNT) ? (sample ? {hist[SYNC_WIDTH-2:0], data_pin_i} : hist) : '0;
            if (stay_aligned) begin
                if (sample) begin
                    shreg <= shift_n;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
            end else begin
                shreg <= '0;
                cnt   <= '0;
            end
            if (state == HUNT && state_n == ALIGNED) msb <= msb_first_i;
            overflow_o <= clear_state_i ? 1'b0 : (overflow_o || drop);
        end
    end
    deser_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clk_en      (clk_en),
        .clear       (clear_state_i),
        .push        (push),
        .ready       (word_ready_i),
        .wdata       (shift_n),
        .valid       (word_valid_o),
        .rdata       (word_data_o),
        .full        (full),
        .drop        (drop)
    );
endmodule

// File: tb/tb_recovered_deserializer.sv
// tb_recovered_deserializer: directed checks of alignment, bit order, buffering, overflow, lock loss and reset
module tb_recovered_deserializer;
    logic       clk = 1'b0;
    logic       async_rst_n, clk_en, deser_en_i, clear_state_i, fully_locked_in_i;
    logic       sample_event_i, data_pin_i, msb_first_i, word_valid_o, word_ready_i, overflow_o;
    logic [7:0] sync_pattern_i, word_data_o;
    logic [1:0] state_o;
    int checks = 0;
    int errors = 0;
    recovered_deserializer dut (
        .clk               (clk),
        .async_rst_n       (async_rst_n),
        .clk_en            (clk_en),
        .deser_en_i        (deser_en_i),
        .clear_state_i     (clear_state_i),
        .fully_locked_in_i (fully_locked_in_i),
        .sample_event_i    (sample_event_i),
        .data_pin_i        (data_pin_i),
        .msb_first_i       (msb_first_i),
        .sync_pattern_i    (sync_pattern_i),
        .word_valid_o      (word_valid_o),
        .word_ready_i      (word_ready_i),
        .word_data_o       (word_data_o),
        .overflow_o        (overflow_o),
        .state_o           (state_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_bit(input logic b, input logic r);
        tick();
        tick();
        data_pin_i     = b;
        sample_event_i = 1'b1;
        word_ready_i   = r;
        tick();
        sample_event_i = 1'b0;
        word_ready_i   = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input logic msb, input logic r_last);
        for (int i = 0; i < 8; i++) send_bit(msb ? b[7-i] : b[i], (i == 7) ? r_last : 1'b0);
    endtask
    task automatic sync();
        send_byte(8'hA5, 1'b1, 1'b0);
        tick();
    endtask
    task automatic restart();
        deser_en_i = 1'b0;
        tick();
        deser_en_i = 1'b1;
        tick();
    endtask
    task automatic drain(input logic [7:0] w [4], input int n, input string tag);
        word_ready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            check(tag, word_data_o, w[k]);
            tick();
        end
        word_ready_i = 1'b0;
        check({tag, "_empty"}, word_valid_o, 1'b0);
    endtask
    logic [7:0] q [4];
    initial begin
        async_rst_n = 1'b0; clk_en = 1'b1; deser_en_i = 1'b1; clear_state_i = 1'b0;
        fully_locked_in_i = 1'b1; sample_event_i = 1'b0; data_pin_i = 1'b0;
        msb_first_i = 1'b1; sync_pattern_i = 8'hA5; word_ready_i = 1'b0;
        #1;
        check("rst_valid", word_valid_o, 1'b0);
        check("rst_data", word_data_o, 8'h00);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_state", state_o, 2'd0);
        tick();
        async_rst_n = 1'b1;
        tick();
        check("hunt_entry", state_o, 2'd1);
        // msb-first alignment and first word latency
        send_byte(8'hA5, 1'b1, 1'b0);
        check("hunt_at_match", state_o, 2'd1);
        tick();
        check("aligned", state_o, 2'd2);
        for (int i = 0; i < 7; i++) send_bit(8'h3C >> (7 - i), 1'b0);
        check("no_early_valid", word_valid_o, 1'b0);
        send_bit(1'b0, 1'b0);
        check("msb_valid", word_valid_o, 1'b1);
        check("msb_data", word_data_o, 8'h3C);
        word_ready_i = 1'b1;
        tick();
        word_ready_i = 1'b0;
        check("pop_empty", word_valid_o, 1'b0);
        // lsb-first, msb_first_i latched at alignment
        deser_en_i = 1'b0;
        tick();
        check("disable_idle", state_o, 2'd0);
        deser_en_i = 1'b1;
        msb_first_i = 1'b0;
        tick();
        sync();
        msb_first_i = 1'b1;
        send_byte(8'h3C, 1'b0, 1'b0);
        check("lsb_valid", word_valid_o, 1'b1);
        check("lsb_data", word_data_o, 8'h3C);
        word_ready_i = 1'b1;
        tick();
        word_ready_i = 1'b0;
        // overflow: five words into a four-deep buffer
        restart();
        sync();
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) send_byte(q[k], 1'b1, 1'b0);
        check("full_no_ovf", overflow_o, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check("ovf_set", overflow_o, 1'b1);
        check("ovf_head", word_data_o, 8'h11);
        drain(q, 4, "ovf_drain");
        check("ovf_sticky", overflow_o, 1'b1);
        // clear with overflow set
        clear_state_i = 1'b1;
        tick();
        clear_state_i = 1'b0;
        check("clr_ovf", overflow_o, 1'b0);
        check("clr_valid", word_valid_o, 1'b0);
        check("clr_state", state_o, 2'd0);
        // push and pop together while full
        sync();
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int k = 0; k < 4; k++) send_byte(q[k], 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b1);
        check("pp_no_ovf", overflow_o, 1'b0);
        check("pp_head", word_data_o, 8'hA2);
        q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        drain(q, 4, "pp_drain");
        // lock loss mid-word, then clean resync
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        fully_locked_in_i = 1'b0;
        tick();
        check("lock_loss_idle", state_o, 2'd0);
        fully_locked_in_i = 1'b1;
        tick();
        check("relock_hunt", state_o, 2'd1);
        sync();
        send_byte(8'h5A, 1'b1, 1'b0);
        check("relock_data", word_data_o, 8'h5A);
        check("relock_valid", word_valid_o, 1'b1);
        // async reset mid-word with clk_en low
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        clk_en = 1'b0;
        async_rst_n = 1'b0;
        #1;
        check("arst_valid", word_valid_o, 1'b0);
        check("arst_data", word_data_o, 8'h00);
        check("arst_state", state_o, 2'd0);
        check("arst_ovf", overflow_o, 1'b0);
        tick();
        async_rst_n = 1'b1;
        tick();
        check("clk_en_freeze", state_o, 2'd0);
        clk_en = 1'b1;
        tick();
        check("clk_en_resume", state_o, 2'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
